// File: rtl/gsensor_pkg.sv
// Shared register-map constants and FSM encoding for the accelerometer SPI model.
// Imported by both the responder and the initiator side.
package gsensor_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CMD,
      ST_RD,
      ST_WR
   } state_t;

   localparam logic [7:0] DEVID_DEFAULT = 8'hE5;

   localparam logic [5:0] ADDR_DEVID       = 6'h00;
   localparam logic [5:0] ADDR_BW_RATE     = 6'h2C;
   localparam logic [5:0] ADDR_POWER_CTL   = 6'h2D;
   localparam logic [5:0] ADDR_INT_ENABLE  = 6'h2E;
   localparam logic [5:0] ADDR_INT_SOURCE  = 6'h30;
   localparam logic [5:0] ADDR_DATA_FORMAT = 6'h31;
   localparam logic [5:0] ADDR_DATAX0      = 6'h32;
   localparam logic [5:0] ADDR_DATAX1      = 6'h33;
   localparam logic [5:0] ADDR_DATAY0      = 6'h34;
   localparam logic [5:0] ADDR_DATAY1      = 6'h35;
   localparam logic [5:0] ADDR_DATAZ0      = 6'h36;
   localparam logic [5:0] ADDR_DATAZ1      = 6'h37;

   localparam logic [7:0] BW_RATE_RESET     = 8'h0A;
   localparam logic [7:0] POWER_CTL_RESET   = 8'h00;
   localparam logic [7:0] INT_ENABLE_RESET  = 8'h00;
   localparam logic [7:0] DATA_FORMAT_RESET = 8'h00;

   localparam int RW_BIT         = 7;
   localparam int MB_BIT         = 6;
   localparam int MEASURE_BIT    = 3;
   localparam int DATA_READY_BIT = 7;

   function automatic logic is_data_addr(input logic [5:0] addr);
      return (addr >= ADDR_DATAX0) && (addr <= ADDR_DATAZ1);
   endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Brings SCLK/CS_N/SDI into the clk domain and flags their edges; SDI is delayed
// through the same depth so it lines up with the SCLK rise pulse.
module spi_pin_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic spi_clk,
   input  logic spi_csn,
   input  logic spi_sdi,
   output logic sclk_rise,
   output logic sclk_fall,
   output logic csn_rise,
   output logic csn_fall,
   output logic sdi
);

   logic [SYNC_STAGES-1:0] sclk_sync;
   logic [SYNC_STAGES-1:0] csn_sync;
   logic [SYNC_STAGES-1:0] sdi_sync;
   logic                   sclk_prev;
   logic                   csn_prev;

   // NOTE: no reset here on purpose: the chains keep tracking the pins through a
   // reset, so a CS_N that is already low never produces a phantom falling edge.
   always_ff @(posedge clk) begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_clk};
      csn_sync  <= {csn_sync[SYNC_STAGES-2:0], spi_csn};
      sdi_sync  <= {sdi_sync[SYNC_STAGES-2:0], spi_sdi};
      sclk_prev <= sclk_sync[SYNC_STAGES-1];
      csn_prev  <= csn_sync[SYNC_STAGES-1];
   end

   assign sclk_rise = sclk_sync[SYNC_STAGES-1] & ~sclk_prev;
   assign sclk_fall = ~sclk_sync[SYNC_STAGES-1] & sclk_prev;
   assign csn_rise  = csn_sync[SYNC_STAGES-1] & ~csn_prev;
   assign csn_fall  = ~csn_sync[SYNC_STAGES-1] & csn_prev;
   assign sdi       = sdi_sync[SYNC_STAGES-1];

endmodule

// File: rtl/gsensor_spi_responder.sv
// Mode-3 SPI responder emulating the accelerometer register map, with a
// coherent per-frame snapshot of the X/Y/Z samples and a data-ready interrupt.
module gsensor_spi_responder
   import gsensor_pkg::*;
#(
   parameter logic [7:0] DEVID       = DEVID_DEFAULT,
   parameter int         SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        spi_clk,
   input  logic        spi_csn,
   input  logic        spi_sdi,
   output logic        spi_sdo,
   output logic        spi_sdo_oe,
   input  logic [15:0] sample_x,
   input  logic [15:0] sample_y,
   input  logic [15:0] sample_z,
   input  logic        sample_valid,
   output logic        int1,
   output logic        frame_err
);

   logic sclk_rise, sclk_fall, csn_rise, csn_fall, sdi;

   spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_pin_sync (
      .clk       (clk),
      .spi_clk   (spi_clk),
      .spi_csn   (spi_csn),
      .spi_sdi   (spi_sdi),
      .sclk_rise (sclk_rise),
      .sclk_fall (sclk_fall),
      .csn_rise  (csn_rise),
      .csn_fall  (csn_fall),
      .sdi       (sdi)
   );

   state_t      state, state_next;
   logic [2:0]  bit_cnt;
   logic [6:0]  shift_in;
   logic [7:0]  rx_byte, sdo_shift, rd_data;
   logic [5:0]  addr, next_addr;
   logic        mb, byte_done, sdo_q, data_accessed;
   logic [7:0]  bw_rate, power_ctl, int_enable, data_format;
   logic        data_ready;
   logic [15:0] shadow_x, shadow_y, shadow_z;
   logic [15:0] frame_x, frame_y, frame_z;

   assign rx_byte   = {shift_in, sdi};
   assign byte_done = sclk_rise && (bit_cnt == 3'd7);

   // NOTE: sequential state uses <= so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_next;
   end

   // NOTE: every output of a combinational block gets a default first, or a
   // missed branch would hold its old value and infer a latch.
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: if (csn_fall) state_next = ST_CMD;
         ST_CMD: begin
            if (csn_rise)       state_next = ST_IDLE;
            else if (byte_done) state_next = rx_byte[RW_BIT] ? ST_RD : ST_WR;
         end
         default: if (csn_rise) state_next = ST_IDLE;
      endcase
   end

   // Address of the byte that starts after the current byte completes.
   always_comb begin
      next_addr = addr;
      if (state == ST_CMD) next_addr = rx_byte[5:0];
      else if (mb)         next_addr = addr + 6'd1;
   end

   always_comb begin
      rd_data = 8'h00;
      case (next_addr)
         ADDR_DEVID:       rd_data = DEVID;
         ADDR_BW_RATE:     rd_data = bw_rate;
         ADDR_POWER_CTL:   rd_data = power_ctl;
         ADDR_INT_ENABLE:  rd_data = int_enable;
         ADDR_INT_SOURCE:  rd_data = {data_ready, 7'b0};
         ADDR_DATA_FORMAT: rd_data = data_format;
         ADDR_DATAX0:      rd_data = frame_x[7:0];
         ADDR_DATAX1:      rd_data = frame_x[15:8];
         ADDR_DATAY0:      rd_data = frame_y[7:0];
         ADDR_DATAY1:      rd_data = frame_y[15:8];
         ADDR_DATAZ0:      rd_data = frame_z[7:0];
         ADDR_DATAZ1:      rd_data = frame_z[15:8];
         default:          rd_data = 8'h00;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         bit_cnt       <= '0;
         shift_in      <= '0;
         addr          <= '0;
         mb            <= 1'b0;
         sdo_shift     <= '0;
         sdo_q         <= 1'b0;
         data_accessed <= 1'b0;
         bw_rate       <= BW_RATE_RESET;
         power_ctl     <= POWER_CTL_RESET;
         int_enable    <= INT_ENABLE_RESET;
         data_format   <= DATA_FORMAT_RESET;
         data_ready    <= 1'b0;
         shadow_x      <= '0;
         shadow_y      <= '0;
         shadow_z      <= '0;
         frame_x       <= '0;
         frame_y       <= '0;
         frame_z       <= '0;
         int1          <= 1'b0;
         frame_err     <= 1'b0;
      end else begin
         frame_err <= 1'b0;
         int1      <= data_ready & int_enable[DATA_READY_BIT];
         if (sample_valid) begin
            shadow_x <= sample_x;
            shadow_y <= sample_y;
            shadow_z <= sample_z;
         end

         if (state == ST_IDLE) begin
            sdo_q <= 1'b0;
            if (csn_fall) begin
               bit_cnt       <= '0;
               data_accessed <= 1'b0;
               frame_x       <= sample_valid ? sample_x : shadow_x;
               frame_y       <= sample_valid ? sample_y : shadow_y;
               frame_z       <= sample_valid ? sample_z : shadow_z;
            end
         end else if (csn_rise) begin
            bit_cnt <= '0;
            if (bit_cnt != 3'd0) frame_err <= 1'b1;
            if (state == ST_RD && data_accessed) data_ready <= 1'b0;
         end else begin
            if (sclk_rise) begin
               shift_in <= rx_byte[6:0];
               bit_cnt  <= bit_cnt + 3'd1;
            end
            if (byte_done) begin
               addr <= next_addr;
               if (state == ST_CMD) mb <= rx_byte[MB_BIT];
               if ((state == ST_CMD && rx_byte[RW_BIT]) || state == ST_RD) sdo_shift <= rd_data;
               if (state == ST_WR) begin
                  case (addr)
                     ADDR_BW_RATE:     bw_rate     <= rx_byte;
                     ADDR_POWER_CTL:   power_ctl   <= rx_byte;
                     ADDR_INT_ENABLE:  int_enable  <= rx_byte;
                     ADDR_DATA_FORMAT: data_format <= rx_byte;
                     default: ;
                  endcase
               end
            end
            if (sclk_fall && state == ST_RD) begin
               sdo_q     <= sdo_shift[7];
               sdo_shift <= {sdo_shift[6:0], 1'b0};
               if (bit_cnt == 3'd0 && is_data_addr(addr)) data_accessed <= 1'b1;
            end
         end

         // A new sample outranks a same-cycle end-of-read clear.
         if (sample_valid && power_ctl[MEASURE_BIT]) data_ready <= 1'b1;
      end
   end

   assign spi_sdo_oe = (state == ST_RD);
   assign spi_sdo    = sdo_q & spi_sdo_oe;

endmodule

// File: tb/tb_gsensor_spi_responder.sv
// Self-checking bench: a bit-banged mode-3 initiator against a byte-level
// register-map model, directed tables for the map and corner sequences, then random frames.
module tb_gsensor_spi_responder;

   localparam int HALF = 8;  // clk cycles per SCLK phase (SCLK = clk/16)

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        spi_clk = 1'b1;
   logic        spi_csn = 1'b1;
   logic        spi_sdi = 1'b0;
   logic        spi_sdo, spi_sdo_oe, int1, frame_err;
   logic [15:0] sample_x = '0, sample_y = '0, sample_z = '0;
   logic        sample_valid = 1'b0;

   gsensor_spi_responder dut (
      .clk          (clk),
      .reset        (reset),
      .spi_clk      (spi_clk),
      .spi_csn      (spi_csn),
      .spi_sdi      (spi_sdi),
      .spi_sdo      (spi_sdo),
      .spi_sdo_oe   (spi_sdo_oe),
      .sample_x     (sample_x),
      .sample_y     (sample_y),
      .sample_z     (sample_z),
      .sample_valid (sample_valid),
      .int1         (int1),
      .frame_err    (frame_err)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int fe_count = 0;

   always @(posedge clk) if (frame_err === 1'b1) fe_count++;

   // Reference model: register contents as the initiator should see them.
   logic [7:0]  m_reg [64];
   logic [15:0] m_shadow [3];
   logic [15:0] m_frame [3];
   bit          m_dr;

   function automatic void m_reset();
      for (int i = 0; i < 64; i++) m_reg[i] = 8'h00;
      m_reg[6'h2C] = 8'h0A;
      for (int k = 0; k < 3; k++) begin
         m_shadow[k] = '0;
         m_frame[k]  = '0;
      end
      m_dr = 1'b0;
   endfunction

   function automatic logic [7:0] m_read(input logic [5:0] a);
      int idx;
      if (a == 6'h00) return 8'hE5;
      if (a == 6'h2C || a == 6'h2D || a == 6'h2E || a == 6'h31) return m_reg[a];
      if (a == 6'h30) return {m_dr, 7'b0};
      if (a >= 6'h32 && a <= 6'h37) begin
         idx = int'(a) - 'h32;
         return m_frame[idx / 2][8 * (idx % 2) +: 8];
      end
      return 8'h00;
   endfunction

   function automatic void m_write(input logic [5:0] a, input logic [7:0] d);
      if (a == 6'h2C || a == 6'h2D || a == 6'h2E || a == 6'h31) m_reg[a] = d;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Shifts the top nbits of tx out MSB first; samples SDO just before each rise.
   task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx,
                           output bit oe_all, output bit oe_any);
      rx = '0;
      oe_all = 1'b1;
      oe_any = 1'b0;
      for (int i = 7; i >= 8 - nbits; i--) begin
         spi_clk = 1'b0;
         spi_sdi = tx[i];
         wait_clk(HALF);
         rx[i]  = spi_sdo;
         oe_all = oe_all & (spi_sdo_oe === 1'b1);
         oe_any = oe_any | (spi_sdo_oe !== 1'b0);
         spi_clk = 1'b1;
         wait_clk(HALF);
      end
   endtask

   task automatic pulse_sample(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
      sample_x = x;
      sample_y = y;
      sample_z = z;
      sample_valid = 1'b1;
      @(negedge clk);
      sample_valid = 1'b0;
      m_shadow[0] = x;
      m_shadow[1] = y;
      m_shadow[2] = z;
      if (m_reg[6'h2D][3]) m_dr = 1'b1;
   endtask

   logic [15:0] p_x, p_y, p_z;  // sample injected mid-frame when pulse_at >= 0

   task automatic do_frame(input bit rd, input bit mb, input logic [5:0] a, input int n,
                           input logic [47:0] wdata, input int pulse_at,
                           output logic [47:0] rdata, output logic [47:0] expv,
                           output bit oe_cmd_any, output bit oe_data_all, output bit oe_data_any);
      logic [7:0] rx;
      logic [5:0] cur;
      bit         o_all, o_any, acc;
      rdata = '0;
      expv = '0;
      oe_data_all = 1'b1;
      oe_data_any = 1'b0;
      acc = 1'b0;
      cur = a;
      for (int k = 0; k < 3; k++) m_frame[k] = m_shadow[k];
      @(negedge clk);
      spi_csn = 1'b0;
      wait_clk(HALF);
      spi_bits({rd, mb, a}, 8, rx, o_all, oe_cmd_any);
      for (int i = 0; i < n; i++) begin
         if (i == pulse_at) pulse_sample(p_x, p_y, p_z);
         if (rd) begin
            expv[8*i +: 8] = m_read(cur);
            if (cur >= 6'h32 && cur <= 6'h37) acc = 1'b1;
         end
         spi_bits(wdata[8*i +: 8], 8, rx, o_all, o_any);
         rdata[8*i +: 8] = rx;
         oe_data_all = oe_data_all & o_all;
         oe_data_any = oe_data_any | o_any;
         if (!rd) m_write(cur, wdata[8*i +: 8]);
         if (mb) cur = cur + 6'd1;
      end
      spi_csn = 1'b1;
      if (rd && acc) m_dr = 1'b0;
      wait_clk(12);
   endtask

   typedef struct {
      bit          rd;
      bit          mb;
      logic [5:0]  addr;
      int          n;
      logic [47:0] data;  // write bytes, first byte in [7:0]
      logic [47:0] exp;   // expected read bytes, first byte in [7:0]
   } vec_t;

   vec_t vecs[$];
   logic [5:0] pick [12] = '{6'h00, 6'h2C, 6'h2D, 6'h2E, 6'h30, 6'h31,
                             6'h32, 6'h33, 6'h34, 6'h35, 6'h36, 6'h37};

   initial begin
      logic [47:0] rdv, exv, wd;
      logic [7:0]  rx;
      logic [5:0]  ra;
      bit          oc, oa, on, rrd, rmb;
      int          fe0, rn;

      m_reset();
      wait_clk(6);
      reset = 1'b0;
      wait_clk(2);
      check("reset_sdo", 64'(spi_sdo), 64'(0));
      check("reset_sdo_oe", 64'(spi_sdo_oe), 64'(0));
      check("reset_int1", 64'(int1), 64'(0));
      check("reset_frame_err", 64'(frame_err), 64'(0));

      vecs.push_back('{rd:1, mb:0, addr:6'h00, n:1, data:48'h0,    exp:48'hE5});
      vecs.push_back('{rd:1, mb:0, addr:6'h2C, n:1, data:48'h0,    exp:48'h0A});
      vecs.push_back('{rd:1, mb:0, addr:6'h2D, n:1, data:48'h0,    exp:48'h00});
      vecs.push_back('{rd:1, mb:0, addr:6'h2E, n:1, data:48'h0,    exp:48'h00});
      vecs.push_back('{rd:1, mb:0, addr:6'h30, n:1, data:48'h0,    exp:48'h00});
      vecs.push_back('{rd:0, mb:0, addr:6'h2D, n:1, data:48'h08,   exp:48'h0});
      vecs.push_back('{rd:0, mb:0, addr:6'h2E, n:1, data:48'h80,   exp:48'h0});
      vecs.push_back('{rd:1, mb:0, addr:6'h2D, n:1, data:48'h0,    exp:48'h08});
      vecs.push_back('{rd:1, mb:0, addr:6'h2E, n:1, data:48'h0,    exp:48'h80});
      vecs.push_back('{rd:0, mb:0, addr:6'h00, n:1, data:48'h12,   exp:48'h0});
      vecs.push_back('{rd:1, mb:0, addr:6'h00, n:1, data:48'h0,    exp:48'hE5});
      vecs.push_back('{rd:1, mb:1, addr:6'h3F, n:3, data:48'h0,    exp:48'h00E500});
      vecs.push_back('{rd:0, mb:0, addr:6'h31, n:2, data:48'h2211, exp:48'h0});
      vecs.push_back('{rd:1, mb:0, addr:6'h31, n:2, data:48'h0,    exp:48'h2222});
      vecs.push_back('{rd:0, mb:1, addr:6'h2C, n:2, data:48'h080C, exp:48'h0});
      vecs.push_back('{rd:1, mb:1, addr:6'h2C, n:3, data:48'h0,    exp:48'h80080C});
      vecs.push_back('{rd:0, mb:0, addr:6'h30, n:1, data:48'hFF,   exp:48'h0});
      vecs.push_back('{rd:1, mb:0, addr:6'h30, n:1, data:48'h0,    exp:48'h00});

      foreach (vecs[v]) begin
         do_frame(vecs[v].rd, vecs[v].mb, vecs[v].addr, vecs[v].n, vecs[v].data, -1,
                  rdv, exv, oc, oa, on);
         check($sformatf("vec%0d_cmd_oe", v), 64'(oc), 64'(0));
         if (vecs[v].rd) begin
            check($sformatf("vec%0d_rdata", v), 64'(rdv), 64'(vecs[v].exp));
            check($sformatf("vec%0d_data_oe", v), 64'(oa), 64'(1));
         end else begin
            check($sformatf("vec%0d_wr_oe", v), 64'(on), 64'(0));
         end
         check($sformatf("vec%0d_oe_after", v), 64'(spi_sdo_oe), 64'(0));
      end
      check("no_frame_err_clean", 64'(fe_count), 64'(0));

      // Data-ready interrupt and a coherent six-byte burst.
      pulse_sample(16'h0123, 16'hFF80, 16'h0100);
      wait_clk(4);
      check("int1_set", 64'(int1), 64'(1));
      do_frame(1, 0, 6'h30, 1, '0, -1, rdv, exv, oc, oa, on);
      check("int_source_ready", 64'(rdv), 64'(8'h80));
      check("int1_kept_after_0x30", 64'(int1), 64'(1));
      do_frame(1, 1, 6'h32, 6, '0, -1, rdv, exv, oc, oa, on);
      check("burst_xyz", 64'(rdv), 64'(48'h0100FF800123));
      check("int1_cleared", 64'(int1), 64'(0));

      // New sample arrives mid-burst: this burst stays on the old snapshot.
      p_x = 16'h1111; p_y = 16'h2222; p_z = 16'h3333;
      do_frame(1, 1, 6'h32, 6, '0, 3, rdv, exv, oc, oa, on);
      check("midburst_old_sample", 64'(rdv), 64'(48'h0100FF800123));
      check("midburst_int1_cleared", 64'(int1), 64'(0));
      do_frame(1, 1, 6'h32, 6, '0, -1, rdv, exv, oc, oa, on);
      check("next_frame_new_sample", 64'(rdv), 64'(48'h333322221111));

      // Write data byte aborted after 4 bits.
      fe0 = fe_count;
      @(negedge clk);
      spi_csn = 1'b0;
      wait_clk(HALF);
      spi_bits(8'h2C, 8, rx, oa, on);
      spi_bits(8'h77, 4, rx, oa, on);
      spi_csn = 1'b1;
      wait_clk(12);
      check("abort_frame_err_pulses", 64'(fe_count - fe0), 64'(1));
      do_frame(1, 0, 6'h2C, 1, '0, -1, rdv, exv, oc, oa, on);
      check("abort_reg_unchanged", 64'(rdv), 64'(8'h0C));

      // Random frames against the model.
      for (int t = 0; t < 40; t++) begin
         if ($urandom_range(0, 3) == 0) begin
            pulse_sample(16'($urandom), 16'($urandom), 16'($urandom));
            wait_clk(4);
         end
         rrd = ($urandom_range(0, 2) != 0);
         rmb = $urandom_range(0, 1) == 1;
         ra  = ($urandom_range(0, 4) == 0) ? 6'($urandom) : pick[$urandom_range(0, 11)];
         rn  = int'($urandom_range(1, 3));
         wd[31:0]  = $urandom;
         wd[47:32] = 16'($urandom);
         if (!rrd && ra == 6'h2D) wd[3] = 1'b1;  // keep measurement mostly on
         do_frame(rrd, rmb, ra, rn, wd, -1, rdv, exv, oc, oa, on);
         if (rrd) check($sformatf("rand%0d_rd_a%0h", t, ra), 64'(rdv), 64'(exv));
         check($sformatf("rand%0d_int1", t), 64'(int1), 64'(m_dr & m_reg[6'h2E][7]));
      end

      // Reset in the middle of a read data byte.
      fe0 = fe_count;
      @(negedge clk);
      spi_csn = 1'b0;
      wait_clk(HALF);
      spi_bits(8'hAC, 8, rx, oa, on);
      spi_bits(8'h00, 4, rx, oa, on);
      check("rd_oe_before_reset", 64'(spi_sdo_oe), 64'(1));
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("reset_releases_oe", 64'(spi_sdo_oe), 64'(0));
      check("reset_releases_sdo", 64'(spi_sdo), 64'(0));
      wait_clk(3);
      reset = 1'b0;
      m_reset();
      spi_bits(8'h00, 4, rx, oa, on);
      check("post_reset_frame_ignored", 64'(on), 64'(0));
      spi_csn = 1'b1;
      wait_clk(12);
      check("post_reset_no_frame_err", 64'(fe_count - fe0), 64'(0));
      check("post_reset_int1", 64'(int1), 64'(0));
      do_frame(1, 0, 6'h2C, 1, '0, -1, rdv, exv, oc, oa, on);
      check("post_reset_bw_rate", 64'(rdv), 64'(8'h0A));
      do_frame(1, 1, 6'h2D, 2, '0, -1, rdv, exv, oc, oa, on);
      check("post_reset_pwr_inten", 64'(rdv), 64'(16'h0000));
      do_frame(1, 1, 6'h32, 2, '0, -1, rdv, exv, oc, oa, on);
      check("post_reset_frame_latch", 64'(rdv), 64'(16'h0000));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
